// File: rtl/softmax_pkg.sv
// Shared types and sizing helpers for the softmax output packer.
package softmax_pkg;

  // Packer control states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  // Default sizing of the attention-probability path.
  localparam int unsigned DEF_D_W        = 8;
  localparam int unsigned DEF_N          = 32;
  localparam int unsigned DEF_PACK       = 4;
  localparam int unsigned DEF_FIFO_DEPTH = 8;
  localparam int unsigned DEF_WORDS      = DEF_N * DEF_N / DEF_PACK;

  // Width of one packed output word.
  function automatic int unsigned packed_w(input int unsigned pack, input int unsigned d_w);
    return pack * d_w;
  endfunction

  // Number of packed words that make up one N x N matrix.
  function automatic int unsigned words_per_matrix(input int unsigned n, input int unsigned pack);
    return (n * n) / pack;
  endfunction

endpackage

// File: rtl/softmax_out_packer_sync_fifo_fwft.sv
// First-word-fall-through synchronous FIFO: the head entry is always visible
// on rdata. A push into a full FIFO only succeeds when a pop happens in the
// same cycle; otherwise it is discarded and the caller flags the loss.
module sync_fifo_fwft #(
  parameter int unsigned WIDTH = 34,
  parameter int unsigned DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic             one_left
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_depth_chk
    $error("sync_fifo_fwft: DEPTH must be a power of two and at least 2");
  end

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             do_push_s;
  logic             do_pop_s;

  assign full     = (cnt_q == CW'(DEPTH));
  assign empty    = (cnt_q == CW'(0));
  assign one_left = (cnt_q == CW'(1));
  assign rdata    = mem_q[rd_ptr_q];

  // Qualify push/pop and compute next pointers and occupancy.
  always_comb begin
    do_push_s = push & (~full | pop);
    do_pop_s  = pop & ~empty;
    wr_ptr_d  = do_push_s ? (wr_ptr_q + PW'(1)) : wr_ptr_q;
    rd_ptr_d  = do_pop_s  ? (rd_ptr_q + PW'(1)) : rd_ptr_q;
    case ({do_push_s, do_pop_s})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Storage and pointer state; storage is zeroed on reset so the head reads 0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else if (clr) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push_s) begin
        mem_q[wr_ptr_q] <= wdata;
      end
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/softmax_out_packer.sv
// Packs the softmax element stream into PACK-wide words, tags each with its
// word address and queues it for the probability buffer. The input stream
// cannot be stalled, so a full queue drops the word and sets a sticky flag.
module softmax_out_packer
  import softmax_pkg::*;
#(
  parameter int unsigned D_W        = DEF_D_W,
  parameter int unsigned N          = DEF_N,
  parameter int unsigned PACK       = DEF_PACK,
  parameter int unsigned FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int unsigned ADDR_W     = $clog2(words_per_matrix(N, PACK))
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  in_valid,
  input  logic signed [D_W-1:0] qin,
  output logic                  wr_en,
  input  logic                  wr_ready,
  output logic [ADDR_W-1:0]     wr_addr,
  output logic [PACK*D_W-1:0]   wr_data,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow
);

  localparam int unsigned WORDS  = words_per_matrix(N, PACK);
  localparam int unsigned WORD_W = packed_w(PACK, D_W);
  localparam int unsigned EW     = ADDR_W + WORD_W;
  localparam int unsigned LANE_W = (PACK > 1) ? $clog2(PACK) : 1;
  localparam logic [LANE_W-1:0] LANE_LAST = LANE_W'(PACK - 1);
  localparam logic [ADDR_W-1:0] WORD_LAST = ADDR_W'(WORDS - 1);

  if ((N % PACK) != 0) begin : g_pack_chk
    $error("softmax_out_packer: N must be a multiple of PACK");
  end

  state_e                      state_q;
  logic [LANE_W-1:0]           lane_q, lane_d;
  logic [ADDR_W-1:0]           word_q, word_d;
  logic [PACK-1:0][D_W-1:0]    part_q;
  logic [PACK-1:0][D_W-1:0]    word_s;
  logic                        busy_q, done_q, overflow_q;

  logic                        push_req_s;
  logic                        pop_s;
  logic [EW-1:0]               fifo_wdata_s;
  logic [EW-1:0]               fifo_rdata_s;
  logic                        fifo_full_s, fifo_empty_s, fifo_one_s;

  assign lane_d       = lane_q + LANE_W'(1);
  assign word_d       = word_q + ADDR_W'(1);
  assign push_req_s   = (state_q == RUN) & ~start & in_valid & (lane_q == LANE_LAST);
  assign pop_s        = wr_en & wr_ready;
  assign fifo_wdata_s = {word_q, word_s};

  // Completed word: the lanes captured so far plus the element arriving now.
  always_comb begin
    word_s           = part_q;
    word_s[PACK-1]   = qin;
  end

  sync_fifo_fwft #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .clr      (start),
    .push     (push_req_s),
    .pop      (pop_s),
    .wdata    (fifo_wdata_s),
    .rdata    (fifo_rdata_s),
    .full     (fifo_full_s),
    .empty    (fifo_empty_s),
    .one_left (fifo_one_s)
  );

  assign wr_en    = ~fifo_empty_s;
  assign wr_addr  = fifo_rdata_s[EW-1 -: ADDR_W];
  assign wr_data  = fifo_rdata_s[WORD_W-1:0];
  assign busy     = busy_q;
  assign done     = done_q;
  assign overflow = overflow_q;

  // Control FSM, lane/word counters, partial word and status flags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      lane_q     <= '0;
      word_q     <= '0;
      part_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else if (start) begin
      state_q    <= RUN;
      lane_q     <= '0;
      word_q     <= '0;
      part_q     <= '0;
      busy_q     <= 1'b1;
      done_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      case (state_q)
        RUN: begin
          if (in_valid) begin
            part_q[lane_q] <= qin;
            if (lane_q == LANE_LAST) begin
              lane_q <= '0;
              // Full with no simultaneous pop: the word is lost.
              if (fifo_full_s && !pop_s) begin
                overflow_q <= 1'b1;
              end
              if (word_q == WORD_LAST) begin
                state_q <= DRAIN;
              end else begin
                word_q <= word_d;
              end
            end else begin
              lane_q <= lane_d;
            end
          end
        end
        DRAIN: begin
          // Leave as soon as the last queued word is being accepted.
          if (fifo_empty_s || (pop_s && fifo_one_s)) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        IDLE, DONE: begin
          state_q <= state_q;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_softmax_out_packer.sv
// Directed bench for softmax_out_packer with N=4, PACK=4, D_W=8. Instance a
// has a 4-deep FIFO, instance b a 2-deep FIFO; both see the same stimulus.
module tb_softmax_out_packer;

  logic              clk;
  logic              rst;
  logic              start;
  logic              in_valid;
  logic signed [7:0] qin;
  logic              wr_ready;

  logic        a_wr_en, a_busy, a_done, a_overflow;
  logic [1:0]  a_wr_addr;
  logic [31:0] a_wr_data;
  logic        b_wr_en, b_busy, b_done, b_overflow;
  logic [1:0]  b_wr_addr;
  logic [31:0] b_wr_data;

  int n_checks = 0;
  int n_fail   = 0;

  logic [33:0] qa[$];
  logic [33:0] qb[$];

  softmax_out_packer #(.D_W(8), .N(4), .PACK(4), .FIFO_DEPTH(4)) dut_a (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .qin(qin),
    .wr_en(a_wr_en), .wr_ready(wr_ready), .wr_addr(a_wr_addr), .wr_data(a_wr_data),
    .busy(a_busy), .done(a_done), .overflow(a_overflow)
  );

  softmax_out_packer #(.D_W(8), .N(4), .PACK(4), .FIFO_DEPTH(2)) dut_b (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .qin(qin),
    .wr_en(b_wr_en), .wr_ready(wr_ready), .wr_addr(b_wr_addr), .wr_data(b_wr_data),
    .busy(b_busy), .done(b_done), .overflow(b_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record every accepted write mid-cycle, when all signals are stable.
  always @(negedge clk) begin
    if (a_wr_en && wr_ready) qa.push_back({a_wr_addr, a_wr_data});
    if (b_wr_en && wr_ready) qb.push_back({b_wr_addr, b_wr_data});
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] exp_word(input logic [7:0] base, input int k);
    logic [31:0] w;
    for (int j = 0; j < 4; j++) w[j*8 +: 8] = base + 8'(4 * k + j);
    return w;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic stream(input logic [7:0] base, input int count, input int max_gap);
    for (int i = 0; i < count; i++) begin
      in_valid = 1'b1;
      qin      = base + 8'(i);
      tick();
      in_valid = 1'b0;
      if (max_gap > 0) repeat ($urandom_range(0, max_gap)) tick();
    end
  endtask

  task automatic wait_done(input string tag, input int bound);
    for (int i = 0; i < bound && !a_done; i++) tick();
    check_eq({tag, "_done"}, 64'(a_done), 64'd1);
  endtask

  task automatic check_words_a(input string tag, input int mark, input logic [7:0] base);
    check_eq({tag, "_count"}, 64'(qa.size() - mark), 64'd4);
    for (int k = 0; k < 4; k++) begin
      if (mark + k < qa.size())
        check_eq($sformatf("%s_w%0d", tag, k), 64'(qa[mark + k]), 64'({2'(k), exp_word(base, k)}));
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check_eq({tag, "_wr_en"},    64'(a_wr_en),    64'd0);
    check_eq({tag, "_wr_addr"},  64'(a_wr_addr),  64'd0);
    check_eq({tag, "_wr_data"},  64'(a_wr_data),  64'd0);
    check_eq({tag, "_busy"},     64'(a_busy),     64'd0);
    check_eq({tag, "_done"},     64'(a_done),     64'd0);
    check_eq({tag, "_overflow"}, 64'(a_overflow), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int mark_a, mark_b;
    rst = 1'b0; start = 1'b0; in_valid = 1'b0; qin = '0; wr_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_idle_outputs("reset");
    rst = 1'b1;
    tick();

    // Elements while IDLE must not form a word.
    stream(8'h55, 4, 0);
    tick();
    check_eq("idle_ignore_wr_en", 64'(a_wr_en), 64'd0);
    check_eq("idle_ignore_q", 64'(qa.size()), 64'd0);

    // Basic back-to-back packing with an always-ready buffer.
    mark_a = qa.size();
    pulse_start();
    check_eq("basic_busy", 64'(a_busy), 64'd1);
    for (int i = 0; i < 16; i++) begin
      in_valid = 1'b1;
      qin      = 8'(1 + i);
      tick();
      if (i % 4 == 3) begin
        check_eq($sformatf("basic_wr_en%0d", i / 4), 64'(a_wr_en), 64'd1);
        check_eq($sformatf("basic_addr%0d", i / 4), 64'(a_wr_addr), 64'(i / 4));
        check_eq($sformatf("basic_data%0d", i / 4), 64'(a_wr_data), 64'(exp_word(8'h01, i / 4)));
      end
    end
    in_valid = 1'b0;
    check_eq("basic_drain_busy", 64'(a_busy), 64'd1);
    check_eq("basic_drain_done", 64'(a_done), 64'd0);
    tick();
    check_eq("basic_done", 64'(a_done), 64'd1);
    check_eq("basic_busy_end", 64'(a_busy), 64'd0);
    check_eq("basic_wr_en_end", 64'(a_wr_en), 64'd0);
    check_eq("basic_overflow", 64'(a_overflow), 64'd0);
    check_words_a("basic", mark_a, 8'h01);

    // Elements while DONE are ignored; then a gapped stream.
    mark_a = qa.size();
    stream(8'h77, 4, 1);
    tick();
    check_eq("done_ignore_q", 64'(qa.size() - mark_a), 64'd0);
    check_eq("done_hold", 64'(a_done), 64'd1);
    pulse_start();
    stream(8'h01, 16, 3);
    wait_done("gap", 40);
    check_words_a("gap", mark_a, 8'h01);

    // Backpressure on instance a; overflow on 2-deep instance b.
    wr_ready = 1'b0;
    mark_a = qa.size();
    mark_b = qb.size();
    pulse_start();
    stream(8'h01, 16, 0);
    for (int i = 0; i < 4; i++) begin
      check_eq($sformatf("bp_hold_addr%0d", i), 64'(a_wr_addr), 64'd0);
      check_eq($sformatf("bp_hold_data%0d", i), 64'(a_wr_data), 64'(exp_word(8'h01, 0)));
      tick();
    end
    check_eq("bp_wr_en", 64'(a_wr_en), 64'd1);
    check_eq("bp_busy", 64'(a_busy), 64'd1);
    check_eq("bp_no_writes", 64'(qa.size() - mark_a), 64'd0);
    check_eq("bp_a_overflow", 64'(a_overflow), 64'd0);
    check_eq("ov_b_overflow", 64'(b_overflow), 64'd1);
    wr_ready = 1'b1;
    for (int i = 0; i < 20 && !(a_done && b_done); i++) tick();
    check_eq("bp_done", 64'(a_done), 64'd1);
    check_eq("ov_done", 64'(b_done), 64'd1);
    check_eq("ov_busy", 64'(b_busy), 64'd0);
    check_words_a("bp", mark_a, 8'h01);
    check_eq("ov_count", 64'(qb.size() - mark_b), 64'd2);
    for (int k = 0; k < 2; k++) begin
      if (mark_b + k < qb.size())
        check_eq($sformatf("ov_w%0d", k), 64'(qb[mark_b + k]), 64'({2'(k), exp_word(8'h01, k)}));
    end
    check_eq("ov_sticky", 64'(b_overflow), 64'd1);

    // Restart mid-matrix; the element in the start cycle is ignored.
    pulse_start();
    stream(8'h01, 6, 0);
    mark_a = qa.size();
    start = 1'b1; in_valid = 1'b1; qin = 8'hEE;
    tick();
    start = 1'b0; in_valid = 1'b0;
    check_eq("restart_wr_en", 64'(a_wr_en), 64'd0);
    check_eq("restart_busy", 64'(a_busy), 64'd1);
    check_eq("restart_ov_clr", 64'(b_overflow), 64'd0);
    stream(8'h21, 16, 0);
    wait_done("restart", 20);
    check_words_a("restart", mark_a, 8'h21);

    // Asynchronous reset in the middle of a stalled matrix.
    wr_ready = 1'b0;
    pulse_start();
    stream(8'h01, 8, 0);
    check_eq("rst_pre_wr_en", 64'(a_wr_en), 64'd1);
    #2;
    rst = 1'b0;
    #1;
    check_idle_outputs("midrst");
    #2;
    rst = 1'b1;
    tick();
    tick();
    check_eq("midrst_after_wr_en", 64'(a_wr_en), 64'd0);
    check_eq("midrst_after_busy", 64'(a_busy), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/softmax_out_packer.md
Name: softmax_out_packer

Overview:
- Receives the signed D_W-bit qout/out_valid stream from the softmax unit, one element per valid cycle, in row-major order of an N x N attention-probability matrix.
- Packs PACK consecutive elements into one wide word and writes each word to the probability buffer through a valid/ready write port.
- A small FIFO absorbs backpressure, because the softmax stream cannot be stalled.
- Raises done when the last word of the matrix has been accepted by the buffer.

Parameters:
- D_W, 8, element width in bits.
- N, 32, matrix dimension; N*N elements per matrix.
- PACK, 4, elements per output word; N must be a multiple of PACK.
- FIFO_DEPTH, 8, word FIFO entries; power of two, >= 2.
- ADDR_W, $clog2(N*N/PACK), word-address width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; arms capture of a new matrix.
- in_valid  in  1  element valid (driven from the softmax out_valid).
- qin  in  D_W  signed element (driven from the softmax qout).
- wr_en  out  1  write request, i.e. the FIFO is non-empty.
- wr_ready  in  1  buffer accepts the word this cycle.
- wr_addr  out  ADDR_W  word address.
- wr_data  out  PACK*D_W  packed word; element k occupies bits [k*D_W +: D_W].
- busy  out  1  high in RUN and DRAIN.
- done  out  1  high in DONE.
- overflow  out  1  sticky; a word was dropped because the FIFO was full.

Behaviour:
- Reset, rst=0, asynchronous: state IDLE, FIFO empty, lane and word counters 0.
  - All outputs 0: wr_en, wr_addr, wr_data, busy, done, overflow.
- States:
  - IDLE: start -> RUN.
  - RUN: in_valid elements are packed. After the last element (word N*N/PACK-1) is pushed -> DRAIN.
  - DRAIN: waits until the FIFO is empty -> DONE.
  - DONE: done=1; held until start -> RUN.
- Any start cycle, from any state:
  - clears the lane counter, word counter, partial word, FIFO and overflow;
  - enters RUN on the next cycle;
  - in_valid in the start cycle itself is ignored.
- in_valid in IDLE, DRAIN or DONE is ignored with no side effects.
- Packing in RUN, on each in_valid:
  - qin is written into lane lane_cnt of the partial word;
  - lane_cnt increments and wraps at PACK-1.
- When lane PACK-1 is written:
  - {word_cnt, assembled word} is pushed into the FIFO at the same clock edge;
  - word_cnt increments.
- Overflow:
  - If the FIFO is full at the push cycle, the word is dropped and overflow is set (sticky).
  - word_cnt still increments, so later addresses stay correct.
  - A simultaneous pop in that cycle counts as not-full: the push succeeds.
- FIFO is first-word fall-through:
  - wr_en = !empty; wr_addr and wr_data are the head entry;
  - pop when wr_en & wr_ready.
- Latency: an element completing a word at edge t makes wr_en=1 in the cycle following t. With wr_ready=1 the packer sustains 1 element/cycle indefinitely.
- Holding rule: while wr_en=1 and wr_ready=0, wr_addr and wr_data hold stable.
- Address rules:
  - wr_addr is never recomputed at the output; it is the pushed word_cnt.
  - word_cnt wraps to 0 only via start or reset; it reaches at most N*N/PACK-1.
- Empty-FIFO pop is impossible because wr_en=0 when empty.
- Simultaneous push and pop on a full FIFO: both occur and the count is unchanged.
- Reset asserted mid-matrix: immediate return to the reset state; partial words and FIFO contents are lost.

Decomposition:
- Shared package softmax_pkg holds:
  - the state enum (IDLE, RUN, DRAIN, DONE);
  - the packed-word width function PACK*D_W;
  - a localparam for the words-per-matrix expression N*N/PACK.
- One sub-module: sync_fifo_fwft, parameterised by width (ADDR_W+PACK*D_W) and depth.
  - Ports: full, empty, push, pop, wdata, rdata.
  - Asynchronous active-low reset.
- Elaboration-time check that N % PACK == 0.

Test Plan:
- Basic pack, N=4, PACK=4, wr_ready=1, elements 0x01..0x10 streamed back-to-back after start:
  - words 0x04030201@0, 0x08070605@1, 0x0C0B0A09@2, 0x100F0E0D@3;
  - each word appears one cycle after its 4th element;
  - done=1 one cycle after the last accept; overflow=0.
- Backpressure, N=4, FIFO_DEPTH=4, wr_ready=0 for 20 cycles then 1:
  - all 4 words are held stable and emitted in order;
  - overflow=0; done follows the final accept.
- Overflow, N=4, FIFO_DEPTH=2, wr_ready=0 throughout the stream:
  - words @0 and @1 are retained; @2 and @3 are dropped;
  - overflow=1; after wr_ready=1, exactly 2 writes occur, then DONE.
- Gapped input, in_valid toggling 1/0 with random gaps, N=4:
  - output words are identical to the basic case.
  - in_valid pulses sent while in IDLE/DONE produce no writes.
- Restart and reset:
  - start issued after 6 elements, then 16 fresh elements 0x21..0x30 -> first word 0x24232221@0; no stale data.
  - rst=0 pulsed mid-stream -> all outputs 0 immediately, FIFO empty.
